// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolve queue.
package branch_pkg;

  // Resolve-queue control states: normal operation and the one-cycle
  // flush window that follows a misprediction.
  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } br_state_e;

  // Size of one instruction; the fall-through PC of a branch is pc + INSN_SIZE.
  localparam int unsigned INSN_SIZE = 4;

  // Default PC width used by the default entry type.
  localparam int BR_PC_WIDTH = 32;

  // One in-flight branch: what was predicted and where it lives.
  typedef struct packed {
    logic                   prediction;
    logic [BR_PC_WIDTH-1:0] pc;
    logic [BR_PC_WIDTH-1:0] target;
  } br_entry_t;

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/predictor signal bundle for the branch resolve queue.
interface branch_resolve_queue_if #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 fetchBranch;
  logic                 fetchPrediction;
  logic [PC_WIDTH-1:0]  fetchPc;
  logic [PC_WIDTH-1:0]  fetchTarget;
  logic                 queueFull;
  logic                 resolveValid;
  logic                 resolveTaken;
  logic [PC_WIDTH-1:0]  resolveTarget;
  logic                 isBranch;
  logic                 lastBranchTaken;
  logic                 mispredict;
  logic [PC_WIDTH-1:0]  redirectPc;
  logic [CNT_WIDTH-1:0] branchCount;
  logic [CNT_WIDTH-1:0] mispredictCount;

  // Pipeline side: fetch/execute drive requests and observe results.
  modport master (
    output fetchBranch, fetchPrediction, fetchPc, fetchTarget,
    output resolveValid, resolveTaken, resolveTarget,
    input  queueFull, isBranch, lastBranchTaken, mispredict, redirectPc,
    input  branchCount, mispredictCount
  );

  // Queue side.
  modport slave (
    input  fetchBranch, fetchPrediction, fetchPc, fetchTarget,
    input  resolveValid, resolveTaken, resolveTarget,
    output queueFull, isBranch, lastBranchTaken, mispredict, redirectPc,
    output branchCount, mispredictCount
  );
endinterface

// File: rtl/branch_queue_fifo.sv
// In-order storage for in-flight branches: circular buffer with occupancy,
// a registered full flag and a synchronous clear used on mispredictions.
module branch_queue_fifo
  import branch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = br_entry_t
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   clr_i,
  input  logic   push_i,
  input  entry_t push_data_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   empty_o,
  output logic   full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  // A clear wins over any same-cycle push or pop; a full queue refuses pushes
  // even when a pop happens in the same cycle.
  assign push_ok_s = push_i & ~full_q & ~clr_i;
  assign pop_ok_s  = pop_i & ~empty_o & ~clr_i;

  assign empty_o = (cnt_q == '0);
  assign full_o  = full_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Next pointer/occupancy values; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
    full_d = (cnt_d == DEPTH_CNT);
  end

  // Pointer, occupancy and full-flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
    end
  end

  // Entry storage; contents are only meaningful between push and pop, so no reset.
  always_ff @(posedge clock) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: tracks predicted branches in order, checks each
// resolution against its prediction, updates the predictor, flushes on a
// misprediction and keeps saturating branch/misprediction statistics.
module branch_resolve_queue
  import branch_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input logic                   clock,
  input logic                   reset,
  branch_resolve_queue_if.slave bus
);

  typedef struct packed {
    logic                prediction;
    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] target;
  } entry_t;

  localparam logic [PC_WIDTH-1:0] INSN_INC = PC_WIDTH'(INSN_SIZE);

  br_state_e            state_q, state_d;
  logic                 run_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 dir_wrong_s;
  logic                 tgt_wrong_s;
  logic                 mis_s;
  logic [PC_WIDTH-1:0]  redirect_s;
  entry_t               push_entry_s;
  entry_t               head_s;
  logic                 fifo_empty_s;
  logic                 fifo_full_s;

  logic                 is_branch_q, is_branch_d;
  logic                 last_taken_q, last_taken_d;
  logic                 mispredict_q, mispredict_d;
  logic [PC_WIDTH-1:0]  redirect_q, redirect_d;
  logic [CNT_WIDTH-1:0] bcnt_q, bcnt_d;
  logic [CNT_WIDTH-1:0] mcnt_q, mcnt_d;

  // Saturating increment: statistics stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_WIDTH'(1);
    end
  endfunction

  // Fetch and execute are only honoured in RUN; in FLUSH fetch is still on
  // the wrong path. Full is the registered flag, so a same-cycle pop never
  // makes room for an enqueue.
  assign run_s  = (state_q == ST_RUN);
  assign push_s = run_s & bus.fetchBranch & ~fifo_full_s;
  assign pop_s  = run_s & bus.resolveValid & ~fifo_empty_s;

  assign push_entry_s = '{prediction: bus.fetchPrediction,
                          pc:         bus.fetchPc,
                          target:     bus.fetchTarget};

  branch_queue_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .clr_i       (mis_s),
    .push_i      (push_s),
    .push_data_i (push_entry_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .empty_o     (fifo_empty_s),
    .full_o      (fifo_full_s)
  );

  // Compare the oldest entry against the actual outcome and pick the corrected PC.
  always_comb begin
    dir_wrong_s = (head_s.prediction != bus.resolveTaken);
    tgt_wrong_s = head_s.prediction & bus.resolveTaken &
                  (head_s.target != bus.resolveTarget);
    mis_s       = pop_s & (dir_wrong_s | tgt_wrong_s);
    if (bus.resolveTaken) begin
      redirect_s = bus.resolveTarget;
    end else begin
      redirect_s = head_s.pc + INSN_INC;
    end
  end

  // FSM next state: a misprediction opens a single flush cycle.
  always_comb begin
    state_d = ST_RUN;
    case (state_q)
      ST_RUN: begin
        if (mis_s) begin
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Next values of the predictor strobes, flush pulse, redirect and counters.
  always_comb begin
    is_branch_d  = pop_s;
    last_taken_d = pop_s & bus.resolveTaken;
    mispredict_d = mis_s;
    redirect_d   = redirect_q;
    bcnt_d       = bcnt_q;
    mcnt_d       = mcnt_q;
    if (pop_s) begin
      bcnt_d = sat_inc(bcnt_q);
    end else begin
      bcnt_d = bcnt_q;
    end
    if (mis_s) begin
      mcnt_d     = sat_inc(mcnt_q);
      redirect_d = redirect_s;
    end else begin
      mcnt_d     = mcnt_q;
      redirect_d = redirect_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_RUN;
      is_branch_q  <= 1'b0;
      last_taken_q <= 1'b0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
      bcnt_q       <= '0;
      mcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      is_branch_q  <= is_branch_d;
      last_taken_q <= last_taken_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
      bcnt_q       <= bcnt_d;
      mcnt_q       <= mcnt_d;
    end
  end

  assign bus.queueFull       = fifo_full_s;
  assign bus.isBranch        = is_branch_q;
  assign bus.lastBranchTaken = last_taken_q;
  assign bus.mispredict      = mispredict_q;
  assign bus.redirectPc      = redirect_q;
  assign bus.branchCount     = bcnt_q;
  assign bus.mispredictCount = mcnt_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: a hand-computed vector table
// for the basic resolve/mispredict cases, then scoreboard-checked sequences
// for the full, flush, saturation and reset corners plus random traffic.
module tb_branch_resolve_queue;
  import branch_pkg::*;

  localparam int DEPTH = 4;
  localparam int PCW   = 32;
  localparam int CNTW  = 4;

  typedef struct {
    logic        isb;
    logic        lbt;
    logic        mis;
    logic        full;
    logic [31:0] redir;
    logic [3:0]  bc;
    logic [3:0]  mc;
  } exp_t;

  typedef struct {
    logic        fb;
    logic        pred;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        rv;
    logic        rt;
    logic [31:0] rtgt;
    exp_t        e;
  } vec_t;

  typedef struct {
    logic        pred;
    logic [31:0] pc;
    logic [31:0] tgt;
  } ment_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  vec_t  tbl [11];
  exp_t  sb [$];
  ment_t mq [$];
  logic        m_flush;
  logic [3:0]  m_bc;
  logic [3:0]  m_mc;
  logic [31:0] m_redir;

  branch_resolve_queue_if #(.PC_WIDTH(PCW), .CNT_WIDTH(CNTW)) bus ();

  branch_resolve_queue #(.DEPTH(DEPTH), .PC_WIDTH(PCW), .CNT_WIDTH(CNTW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_out(input string tag, input exp_t e);
    chk({tag, ".isBranch"},        {31'd0, bus.isBranch},        {31'd0, e.isb});
    chk({tag, ".mispredict"},      {31'd0, bus.mispredict},      {31'd0, e.mis});
    chk({tag, ".queueFull"},       {31'd0, bus.queueFull},       {31'd0, e.full});
    chk({tag, ".redirectPc"},      bus.redirectPc,               e.redir);
    chk({tag, ".branchCount"},     {28'd0, bus.branchCount},     {28'd0, e.bc});
    chk({tag, ".mispredictCount"}, {28'd0, bus.mispredictCount}, {28'd0, e.mc});
    if (e.isb) begin
      chk({tag, ".lastBranchTaken"}, {31'd0, bus.lastBranchTaken}, {31'd0, e.lbt});
    end
  endtask

  task automatic drive(input logic fb, input logic pred, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic rv, input logic rt,
                       input logic [31:0] rtgt);
    bus.fetchBranch     = fb;
    bus.fetchPrediction = pred;
    bus.fetchPc         = pc;
    bus.fetchTarget     = tgt;
    bus.resolveValid    = rv;
    bus.resolveTaken    = rt;
    bus.resolveTarget   = rtgt;
  endtask

  // Behavioural reference: predicts the outputs visible after the next edge.
  task automatic model_step(input logic rst, input logic fb, input logic pred,
                            input logic [31:0] pc, input logic [31:0] tgt,
                            input logic rv, input logic rt, input logic [31:0] rtgt);
    exp_t  e;
    ment_t h;
    logic  run, pop, push, mis;
    e = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 4'd0};
    if (rst) begin
      mq.delete();
      m_flush = 1'b0;
      m_bc    = 4'd0;
      m_mc    = 4'd0;
      m_redir = 32'd0;
    end else begin
      run  = !m_flush;
      pop  = run && rv && (mq.size() != 0);
      push = run && fb && (mq.size() != DEPTH);
      mis  = 1'b0;
      if (pop) begin
        h   = mq[0];
        mis = (h.pred != rt) || (h.pred && rt && (h.tgt != rtgt));
        if (m_bc != 4'hF) m_bc = m_bc + 4'd1;
        if (mis) begin
          if (m_mc != 4'hF) m_mc = m_mc + 4'd1;
          m_redir = rt ? rtgt : (h.pc + 32'd4);
        end
      end
      if (mis) begin
        mq.delete();
      end else begin
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back('{pred, pc, tgt});
      end
      m_flush = mis;
      e.isb = pop;
      e.lbt = pop && rt;
      e.mis = mis;
    end
    e.full  = (mq.size() == DEPTH);
    e.redir = m_redir;
    e.bc    = m_bc;
    e.mc    = m_mc;
    sb.push_back(e);
  endtask

  // One scoreboarded cycle: drive, predict, clock, compare.
  task automatic sb_cycle(input string tag, input logic rst, input logic fb,
                          input logic pred, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic rv, input logic rt, input logic [31:0] rtgt);
    exp_t e;
    reset = rst;
    drive(fb, pred, pc, tgt, rv, rt, rtgt);
    model_step(rst, fb, pred, pc, tgt, rv, rt, rtgt);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      compare_out(tag, e);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);

    // Vectors: fb pred pc tgt rv rt rtgt / isb lbt mis full redir bc mc
    tbl[0]  = '{1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 1'b0, 32'h0,   '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'd0, 4'd0}};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,   32'h0,   1'b1, 1'b1, 32'h200, '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   4'd1, 4'd0}};
    tbl[2]  = '{1'b1, 1'b0, 32'h40,  32'h60,  1'b0, 1'b0, 32'h0,   '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   4'd1, 4'd0}};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,   32'h0,   1'b1, 1'b1, 32'h80,  '{1'b1, 1'b1, 1'b1, 1'b0, 32'h80,  4'd2, 4'd1}};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h0,   '{1'b0, 1'b0, 1'b0, 1'b0, 32'h80,  4'd2, 4'd1}};
    tbl[5]  = '{1'b1, 1'b1, 32'h40,  32'h90,  1'b0, 1'b0, 32'h0,   '{1'b0, 1'b0, 1'b0, 1'b0, 32'h80,  4'd2, 4'd1}};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,   32'h0,   1'b1, 1'b0, 32'h0,   '{1'b1, 1'b0, 1'b1, 1'b0, 32'h44,  4'd3, 4'd2}};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h0,   '{1'b0, 1'b0, 1'b0, 1'b0, 32'h44,  4'd3, 4'd2}};
    tbl[8]  = '{1'b1, 1'b1, 32'h280, 32'h300, 1'b0, 1'b0, 32'h0,   '{1'b0, 1'b0, 1'b0, 1'b0, 32'h44,  4'd3, 4'd2}};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,   32'h0,   1'b1, 1'b1, 32'h304, '{1'b1, 1'b1, 1'b1, 1'b0, 32'h304, 4'd4, 4'd3}};
    tbl[10] = '{1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 32'h0,   '{1'b0, 1'b0, 1'b0, 1'b0, 32'h304, 4'd4, 4'd3}};

    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    chk("reset.queueFull",       {31'd0, bus.queueFull},       32'd0);
    chk("reset.isBranch",        {31'd0, bus.isBranch},        32'd0);
    chk("reset.lastBranchTaken", {31'd0, bus.lastBranchTaken}, 32'd0);
    chk("reset.mispredict",      {31'd0, bus.mispredict},      32'd0);
    chk("reset.redirectPc",      bus.redirectPc,               32'd0);
    chk("reset.branchCount",     {28'd0, bus.branchCount},     32'd0);
    chk("reset.mispredictCount", {28'd0, bus.mispredictCount}, 32'd0);

    // Table: correct resolve, direction mispredicts, wrong-target mispredict.
    reset = 1'b0;
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].fb, tbl[i].pred, tbl[i].pc, tbl[i].tgt, tbl[i].rv, tbl[i].rt, tbl[i].rtgt);
      @(posedge clock);
      #1;
      compare_out($sformatf("vec%0d", i), tbl[i].e);
    end

    // Fill to DEPTH, then pop+push while full: only the pop happens.
    sb_cycle("t4.rst", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      sb_cycle("t4.fill", 1'b0, 1'b1, 1'b0, 32'h1000 + 32'(i * 16), 32'h2000, 1'b0, 1'b0, 32'h0);
    end
    chk("t4.full_after_fill", {31'd0, bus.queueFull}, 32'd1);
    sb_cycle("t4.popfull", 1'b0, 1'b1, 1'b0, 32'h1F00, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("t4.full_after_pop", {31'd0, bus.queueFull}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      sb_cycle("t4.drain", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    end
    chk("t4.drain_empty_no_strobe", {31'd0, bus.isBranch}, 32'd0);

    // Oldest of three mispredicts with fetch active; flush ignores everything.
    sb_cycle("t5.rst", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      sb_cycle("t5.fill", 1'b0, 1'b1, 1'b1, 32'h10 + 32'(i * 16), 32'h500, 1'b0, 1'b0, 32'h0);
    end
    sb_cycle("t5.mis", 1'b0, 1'b1, 1'b1, 32'h40, 32'h500, 1'b1, 1'b0, 32'h0);
    chk("t5.redirect", bus.redirectPc, 32'h14);
    sb_cycle("t5.flush", 1'b0, 1'b1, 1'b1, 32'h50, 32'h500, 1'b1, 1'b1, 32'h500);
    chk("t5.flush_no_strobe", {31'd0, bus.isBranch}, 32'd0);
    sb_cycle("t5.empty_rv", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h500);
    chk("t5.empty_no_strobe", {31'd0, bus.isBranch}, 32'd0);
    sb_cycle("t5.enq", 1'b0, 1'b1, 1'b0, 32'h60, 32'h0, 1'b0, 1'b0, 32'h0);
    sb_cycle("t5.res", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);

    // Saturate both counters, then one more mispredict, then reset mid-queue.
    sb_cycle("t6.rst", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 17; i++) begin
      sb_cycle("t6.enq", 1'b0, 1'b1, 1'b1, 32'h700, 32'h800, 1'b0, 1'b0, 32'h0);
      sb_cycle("t6.mis", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      sb_cycle("t6.idle", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    end
    chk("t6.bc_sat", {28'd0, bus.branchCount},     32'hF);
    chk("t6.mc_sat", {28'd0, bus.mispredictCount}, 32'hF);
    sb_cycle("t6.enq2", 1'b0, 1'b1, 1'b1, 32'h900, 32'hA00, 1'b0, 1'b0, 32'h0);
    sb_cycle("t6.enq3", 1'b0, 1'b1, 1'b0, 32'h910, 32'h0, 1'b1, 1'b0, 32'h0);
    sb_cycle("t6.midrst", 1'b1, 1'b1, 1'b0, 32'h920, 32'h0, 1'b1, 1'b1, 32'hA00);
    chk("t6.rst_bc", {28'd0, bus.branchCount}, 32'd0);
    sb_cycle("t6.post_rst_rv", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hA00);

    // Random legal traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic        r_rst, r_fb, r_pred, r_rv, r_rt;
      logic [31:0] r_pc, r_tgt, r_rtgt;
      r_rst  = ($urandom_range(0, 79) == 0);
      r_fb   = (mq.size() != DEPTH) && ($urandom_range(0, 2) != 0);
      r_pred = 1'($urandom_range(0, 1));
      r_pc   = {20'd0, 10'($urandom), 2'b00};
      r_tgt  = $urandom_range(0, 3) == 0 ? 32'h104 : 32'h100;
      r_rv   = ($urandom_range(0, 2) != 0);
      r_rt   = 1'($urandom_range(0, 1));
      r_rtgt = $urandom_range(0, 3) == 0 ? 32'h104 : 32'h100;
      sb_cycle("rand", r_rst, r_fb, r_pred, r_pc, r_tgt, r_rv, r_rt, r_rtgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
